// File: rtl/mmio_user_io.sv
// Generic circular-buffer FIFO with combinational head (out_dat shows mem[rd_ptr]).
// Latency: an entry written at one edge can be read from the next cycle; nothing bypasses the buffer.
// Backpressure: in_rdy stays high when full if the same cycle pops; a push offered while in_rdy is low is lost.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_dat,
    output logic             in_rdy,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat,
    input  logic             out_rdy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             push;
    logic             pop;

    assign out_vld = (count != '0);
    assign out_dat = mem[rd_ptr];
    assign pop     = out_vld && out_rdy;
    assign in_rdy  = (count != FULL_CNT) || pop;
    assign push    = in_vld && in_rdy;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_dat;
    end

    // DEPTH is a power of two, so the pointers wrap by overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// User IO slave for the 0x8000_00xx region: counters, button-event FIFO, switches, LEDs.
// Latency: load data is registered, valid the cycle after re; stores take effect at the sampling edge.
// Backpressure: none toward the CPU; button events arriving at a full FIFO with no pop are dropped.
module mmio_user_io #(
    parameter int FIFO_DEPTH = 8,
    parameter int N_BUTTONS  = 3,
    parameter int N_SWITCHES = 2,
    parameter int N_LEDS     = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            addr,
    input  logic                  re,
    input  logic                  we,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    input  logic                  inst_retire,
    input  logic [N_BUTTONS-1:0]  clean_buttons,
    input  logic [N_SWITCHES-1:0] switches,
    output logic [N_LEDS-1:0]     leds
);
    localparam logic [5:0] W_CYCLE = 6'h04;  // 0x10
    localparam logic [5:0] W_INST  = 6'h05;  // 0x14
    localparam logic [5:0] W_CRST  = 6'h06;  // 0x18
    localparam logic [5:0] W_EMPTY = 6'h08;  // 0x20
    localparam logic [5:0] W_POP   = 6'h09;  // 0x24
    localparam logic [5:0] W_SW    = 6'h0A;  // 0x28
    localparam logic [5:0] W_LEDW  = 6'h0C;  // 0x30
    localparam logic [5:0] W_LEDR  = 6'h0D;  // 0x34

    logic [5:0]           word;
    logic [31:0]          cycle_cnt;
    logic [31:0]          inst_cnt;
    logic [N_BUTTONS-1:0] btn_prev;
    logic [N_BUTTONS-1:0] rise;
    logic                 fifo_in_rdy;
    logic                 fifo_vld;
    logic [N_BUTTONS-1:0] fifo_head;
    logic                 pop_req;
    logic [31:0]          rd_mux;

    assign word    = 6'(addr >> 2);
    assign rise    = clean_buttons & ~btn_prev;
    assign pop_req = re && (word == W_POP);

    fifo #(
        .WIDTH (N_BUTTONS),
        .DEPTH (FIFO_DEPTH)
    ) u_btn_fifo (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (|rise),
        .in_dat  (rise),
        .in_rdy  (fifo_in_rdy),
        .out_vld (fifo_vld),
        .out_dat (fifo_head),
        .out_rdy (pop_req)
    );

    always_comb begin
        rd_mux = '0;
        case (word)
            W_CYCLE: rd_mux = cycle_cnt;
            W_INST:  rd_mux = inst_cnt;
            W_EMPTY: rd_mux = 32'(!fifo_vld);
            W_POP:   rd_mux = fifo_vld ? 32'(fifo_head) : '0;
            W_SW:    rd_mux = 32'(switches);
            W_LEDR:  rd_mux = 32'(leds);
            default: rd_mux = '0;
        endcase
    end

    // Resetting btn_prev to all ones keeps a button held through reset from raising an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
            btn_prev  <= '1;
            leds      <= '0;
            rdata     <= '0;
        end else begin
            btn_prev <= clean_buttons;
            if (we && (word == W_CRST)) begin
                cycle_cnt <= '0;
                inst_cnt  <= '0;
            end else begin
                cycle_cnt <= cycle_cnt + 32'd1;
                inst_cnt  <= inst_cnt + 32'(inst_retire);
            end
            if (we && (word == W_LEDW))
                leds <= N_LEDS'(wdata);
            if (re)
                rdata <= rd_mux;
        end
    end

    logic unused_ok;
    assign unused_ok = fifo_in_rdy;
endmodule

// File: tb/tb_mmio_user_io.sv
// Directed bench for mmio_user_io: inputs change on the falling edge, outputs are checked on the
// following falling edge with immediate assertions against hand-computed values.
module tb_mmio_user_io;
    logic        clk;
    logic        rst;
    logic [7:0]  addr;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        inst_retire;
    logic [2:0]  clean_buttons;
    logic [1:0]  switches;
    logic [5:0]  leds;

    int checks = 0;
    int errors = 0;

    mmio_user_io dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .re            (re),
        .we            (we),
        .wdata         (wdata),
        .rdata         (rdata),
        .inst_retire   (inst_retire),
        .clean_buttons (clean_buttons),
        .switches      (switches),
        .leds          (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One-cycle load; on return rdata holds the value sampled at that edge.
    task automatic rd(input logic [7:0] a);
        addr = a;
        re   = 1'b1;
        @(negedge clk);
        re   = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic press(input logic [2:0] v);
        clean_buttons = v;
        @(negedge clk);
        clean_buttons = 3'b000;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; addr = 8'h00; re = 1'b0; we = 1'b0; wdata = '0;
        inst_retire = 1'b0; clean_buttons = 3'b000; switches = 2'b00;

        // T1: reset state and cycle counting
        @(negedge clk);
        rst = 1'b0;
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_leds", 32'(leds), 32'd0);
        repeat (10) @(negedge clk);
        rd(8'h10);
        chk("t1_cycle_cnt", rdata, 32'd10);
        rd(8'h14);
        chk("t1_inst_cnt", rdata, 32'd0);
        @(negedge clk);
        chk("rdata_hold", rdata, 32'd0);

        // T2: retire counting and counter reset beating a same-cycle retire
        inst_retire = 1'b1;
        repeat (20) @(negedge clk);
        inst_retire = 1'b0;
        rd(8'h14);
        chk("t2_inst_20", rdata, 32'd20);
        inst_retire = 1'b1;
        wr(8'h18, 32'hDEAD_BEEF);
        inst_retire = 1'b0;
        repeat (3) @(negedge clk);
        rd(8'h10);
        chk("t2_cycle_after_crst", rdata, 32'd3);
        rd(8'h14);
        chk("t2_inst_after_crst", rdata, 32'd0);

        // T3: single merged event
        rd(8'h20);
        chk("t3_empty_initial", rdata, 32'd1);
        clean_buttons = 3'b101;
        @(negedge clk);
        rd(8'h20);
        chk("t3_not_empty", rdata, 32'd0);
        rd(8'h24);
        chk("t3_pop_101", rdata, 32'd5);
        rd(8'h20);
        chk("t3_empty_after_pop", rdata, 32'd1);
        clean_buttons = 3'b000;
        @(negedge clk);

        // T4: overflow drops the extra events
        for (int i = 0; i < 10; i++) press(3'b001);
        for (int i = 0; i < 8; i++) begin
            rd(8'h24);
            chk($sformatf("t4_pop%0d", i), rdata, 32'd1);
        end
        rd(8'h24);
        chk("t4_pop_empty", rdata, 32'd0);
        rd(8'h20);
        chk("t4_empty_flag", rdata, 32'd1);

        // T5: push+pop while full keeps count at 8 and order oldest-first
        press(3'd1); press(3'd2); press(3'd3); press(3'd4);
        press(3'd5); press(3'd6); press(3'd7); press(3'd1);
        clean_buttons = 3'b110;
        rd(8'h24);
        clean_buttons = 3'b000;
        chk("t5_full_pushpop", rdata, 32'd1);
        begin
            logic [2:0] exp_q [8];
            exp_q = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd6};
            for (int i = 0; i < 8; i++) begin
                rd(8'h24);
                chk($sformatf("t5_order%0d", i), rdata, 32'(exp_q[i]));
            end
        end
        rd(8'h20);
        chk("t5_drained", rdata, 32'd1);

        // Push and pop while empty: read returns 0, push still lands
        clean_buttons = 3'b010;
        rd(8'h24);
        clean_buttons = 3'b000;
        chk("empty_pushpop_rd", rdata, 32'd0);
        rd(8'h24);
        chk("empty_pushpop_landed", rdata, 32'd2);

        // T6: switches, LEDs, unmapped offsets, ignored addr[1:0]
        switches = 2'b10;
        rd(8'h28);
        chk("t6_switches", rdata, 32'd2);
        wr(8'h30, 32'hFFFF_FFE5);
        chk("t6_leds_port", 32'(leds), 32'h25);
        rd(8'h34);
        chk("t6_leds_read", rdata, 32'h25);
        rd(8'h36);
        chk("t6_addr_lsb_ignored", rdata, 32'h25);
        wr(8'h3C, 32'h0000_0000);
        rd(8'h3C);
        chk("t6_unmapped_read", rdata, 32'd0);
        chk("t6_unmapped_write", 32'(leds), 32'h25);

        // Mid-run reset with a queued event and buttons held through reset
        press(3'b001);
        clean_buttons = 3'b111;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rd(8'h20);
        chk("rst_fifo_empty", rdata, 32'd1);
        rd(8'h10);
        chk("rst_cycle_cnt", rdata, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
